uart_autobaud_ctrl: RTL and testbench
=====================================

# uart_autobaud_ctrl

Auto-baud controller for the UART receive path. It measures the start-bit width of a sync character on `RX` and classifies it into one of four rate codes. It then drives the 2-bit rate select into the UART RX and enables that receiver only once the rate is locked. It sits between the `RX` pin and the UART RX / RX FIFO chain inside `TOP`, and exports its rate code as `oRate`.

## Interface

Parameters:
- `BIT0`, 10417: nominal bit period in clk cycles for rate code 0 (9600 Bd at 100 MHz).
- `BIT1`, 5208: bit period for code 1 (19200 Bd).
- `BIT2`, 1736: bit period for code 2 (57600 Bd).
- `BIT3`, 868: bit period for code 3 (115200 Bd).
- `IDLE_CYC`, 20000: consecutive high cycles required before arming.
- `DEFAULT_RATE`, 2'd0: `oRate` value after reset.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-high reset.
- `RX`, input, 1: raw serial line, idle high, asynchronous to `clk`.
- `iRelock`, input, 1: one-cycle request to drop lock and re-measure.
- `oRate`, output, 2: rate select to the UART RX.
- `oLocked`, output, 1: high while the rate is valid.
- `oRxEn`, output, 1: enable to the UART RX; equals `oLocked`.
- `oErr`, output, 1: one-cycle pulse when a measurement is rejected.
- `oMeasure`, output, 16: low-cycle count of the last completed measurement.

## Operation

- `RX` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `srx`.
- Reset values: `oRate`=`DEFAULT_RATE`, `oLocked`=0, `oRxEn`=0, `oErr`=0, `oMeasure`=0. The FSM resets to IDLE_WAIT and the idle counter to 0.
- FSM states and transitions:
  - IDLE_WAIT: the idle counter increments while `srx`=1 and clears to 0 when `srx`=0. When the counter reaches `IDLE_CYC`, go to ARMED.
  - ARMED: on `srx`=0, go to MEASURE and load the count with 1.
  - MEASURE: the count increments each cycle `srx`=0, saturating at 16'hFFFF. On `srx`=1, go to CLASSIFY. If the count reaches 16'hFFFF (break condition), go to ERR.
  - CLASSIFY (one cycle): latch the count into `oMeasure`. Code k matches when BITk−(BITk>>3) ≤ count ≤ BITk+(BITk>>3), inclusive. The windows are disjoint.
    - On a match: `oRate`←k, go to LOCKED.
    - On no match: go to ERR.
  - ERR (one cycle): `oErr`=1, `oRate` unchanged, go to IDLE_WAIT with the idle counter cleared.
  - LOCKED: `oLocked`=`oRxEn`=1 and `RX` is ignored. On `iRelock`, go to IDLE_WAIT; `oLocked`/`oRxEn` drop the next cycle and `oRate` holds its last value.
- `iRelock` has no effect outside LOCKED.
- The sync character must have bit0=1 (e.g. 0x55) so that the first low pulse equals exactly one bit. The sync character is consumed here and never reaches the FIFO, because `oRxEn`=0 until after its start bit.
- A low glitch during IDLE_WAIT only restarts the idle count; it never starts a measurement.

## Timing

- Synchronizer latency is 2 cycles from `RX` to `srx`.
- The measured count equals the number of `clk` cycles that `srx` is low.
- `oLocked`, `oRxEn`, `oRate` and `oMeasure` update in the cycle after CLASSIFY, which is 1 cycle after the rising `srx` edge is seen. From the rising edge on `RX`, `oLocked` rises 4 cycles later.
- `oErr` is high for exactly one cycle, at the same relative point, 4 cycles after the rising `RX` edge.
- All outputs are registered.
- Reset asserted mid-measurement returns every output to its reset value immediately, with no `oErr` pulse.
- Once `oLocked`=1 it stays stable until `iRelock` or `reset`.

## Test plan

- Reset: hold `reset`=1 for 2 cycles, then `RX`=1 for 30000 cycles → `oRate`=0, `oLocked`=0, `oRxEn`=0, `oErr` never pulses.
- 9600 lock: idle ≥ 20000 cycles, then `RX` low for 104166 ns followed by 0x55 data bits → `oMeasure`≈10417, `oRate`=0, `oLocked`=`oRxEn`=1. Following frames at 9600 are received into the FIFO.
- 115200 lock: start bit of 868 cycles → `oRate`=3, `oLocked`=1. Low pulses of 976 cycles lock to code 3; 977 cycles → `oErr` pulse and `oLocked`=0.
- Reject and retry: low pulse of 7000 cycles → one `oErr` pulse, `oMeasure`=7000, `oRate` unchanged. After 20000 idle cycles, a 5208-cycle pulse → `oRate`=1, locked.
- Relock and glitch:
  - In LOCKED, pulse `iRelock` → `oLocked` drops next cycle.
  - A 50-cycle low glitch at idle count 15000 delays arming until a fresh 20000 high cycles.
  - A subsequent 1736-cycle pulse → `oRate`=2.
- Reset mid-measure: assert `reset` 500 cycles into a low pulse → all outputs return to reset values with no `oErr`. After release, a clean 868-cycle measurement → `oRate`=3.

Source files
------------

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures the start-bit width of a sync character on RX,
// classifies it into one of four rate codes and enables the UART RX once locked.
module uart_autobaud_ctrl #(
  parameter int unsigned BIT0         = 10417,
  parameter int unsigned BIT1         = 5208,
  parameter int unsigned BIT2         = 1736,
  parameter int unsigned BIT3         = 868,
  parameter int unsigned IDLE_CYC     = 20000,
  parameter logic [1:0]  DEFAULT_RATE = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  input  logic        iRelock,
  output logic [1:0]  oRate,
  output logic        oLocked,
  output logic        oRxEn,
  output logic        oErr,
  output logic [15:0] oMeasure
);

  localparam int unsigned Lo0 = BIT0 - (BIT0 >> 3);
  localparam int unsigned Hi0 = BIT0 + (BIT0 >> 3);
  localparam int unsigned Lo1 = BIT1 - (BIT1 >> 3);
  localparam int unsigned Hi1 = BIT1 + (BIT1 >> 3);
  localparam int unsigned Lo2 = BIT2 - (BIT2 >> 3);
  localparam int unsigned Hi2 = BIT2 + (BIT2 >> 3);
  localparam int unsigned Lo3 = BIT3 - (BIT3 >> 3);
  localparam int unsigned Hi3 = BIT3 + (BIT3 >> 3);

  typedef enum logic [2:0] {
    StIdleWait,
    StArmed,
    StMeasure,
    StClassify,
    StErr,
    StLocked
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, srx_q;
  logic [31:0] idle_q, idle_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] cnt_w;
  logic [1:0]  rate_q, rate_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [15:0] meas_q, meas_d;
  logic        match;
  logic [1:0]  match_code;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      srx_q     <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      srx_q     <= rx_meta_q;
    end
  end

  assign cnt_w = {16'd0, cnt_q};

  always_comb begin
    match      = 1'b1;
    match_code = 2'd0;
    if (cnt_w >= Lo0 && cnt_w <= Hi0) begin
      match_code = 2'd0;
    end else if (cnt_w >= Lo1 && cnt_w <= Hi1) begin
      match_code = 2'd1;
    end else if (cnt_w >= Lo2 && cnt_w <= Hi2) begin
      match_code = 2'd2;
    end else if (cnt_w >= Lo3 && cnt_w <= Hi3) begin
      match_code = 2'd3;
    end else begin
      match = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdleWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdleWait: if (idle_q == IDLE_CYC) state_d = StArmed;
      StArmed:    if (!srx_q) state_d = StMeasure;
      StMeasure: begin
        // A line held low long enough to saturate is a break, not a start bit.
        if (cnt_q == 16'hFFFF) begin
          state_d = StErr;
        end else if (srx_q) begin
          state_d = StClassify;
        end
      end
      StClassify: state_d = match ? StLocked : StErr;
      StErr:      state_d = StIdleWait;
      StLocked:   if (iRelock) state_d = StIdleWait;
      default:    state_d = StIdleWait;
    endcase
  end

  always_comb begin
    idle_d   = 32'd0;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    meas_d   = meas_q;
    locked_d = (state_d == StLocked);
    err_d    = (state_d == StErr);
    if (state_q == StIdleWait && srx_q && idle_q != IDLE_CYC) begin
      idle_d = idle_q + 32'd1;
    end
    if (state_q == StArmed && !srx_q) begin
      cnt_d = 16'd1;
    end else if (state_q == StMeasure && !srx_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (state_q == StClassify) begin
      meas_d = cnt_q;
      if (match) rate_d = match_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q   <= 32'd0;
      cnt_q    <= 16'd0;
      rate_q   <= DEFAULT_RATE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      meas_q   <= 16'd0;
    end else begin
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      meas_q   <= meas_d;
    end
  end

  assign oRate    = rate_q;
  assign oLocked  = locked_q;
  assign oRxEn    = locked_q;
  assign oErr     = err_q;
  assign oMeasure = meas_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Scoreboard bench for uart_autobaud_ctrl with scaled-down bit periods so every
// scenario fits in a short run; lock/error events are checked by a separate monitor.
module tb_uart_autobaud_ctrl;

  // Scaled windows: code0 700..900, code1 350..450, code2 140..180, code3 70..90.
  localparam int unsigned TB_BIT0 = 800;
  localparam int unsigned TB_BIT1 = 400;
  localparam int unsigned TB_BIT2 = 160;
  localparam int unsigned TB_BIT3 = 80;
  localparam int unsigned TB_IDLE = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        RX;
  logic        iRelock;
  logic [1:0]  oRate;
  logic        oLocked;
  logic        oRxEn;
  logic        oErr;
  logic [15:0] oMeasure;

  uart_autobaud_ctrl #(
    .BIT0        (TB_BIT0),
    .BIT1        (TB_BIT1),
    .BIT2        (TB_BIT2),
    .BIT3        (TB_BIT3),
    .IDLE_CYC    (TB_IDLE),
    .DEFAULT_RATE(2'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .RX      (RX),
    .iRelock (iRelock),
    .oRate   (oRate),
    .oLocked (oLocked),
    .oRxEn   (oRxEn),
    .oErr    (oErr),
    .oMeasure(oMeasure)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [1:0]  rate;
    logic [15:0] meas;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every oErr pulse or oLocked rise must match the head of the scoreboard.
  logic locked_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (oErr || (oLocked && !locked_prev))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: err=%0d locked=%0d, required no event (cycle %0d)",
                 oErr, oLocked, cyc);
      end else begin
        e = sb.pop_front();
        check("event_is_err", {31'd0, oErr}, {31'd0, e.is_err});
        check("event_rate", {30'd0, oRate}, {30'd0, e.rate});
        check("event_measure", {16'd0, oMeasure}, {16'd0, e.meas});
        check("event_latency", cyc, e.at);
        check("event_locked", {31'd0, oLocked}, {31'd0, !e.is_err});
        check("event_rxen", {31'd0, oRxEn}, {31'd0, !e.is_err});
      end
    end
    locked_prev = oLocked;
  end

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    RX = 1'b0;
    repeat (n) @(negedge clk);
    RX = 1'b1;
  endtask

  // Low pulse of n cycles; the result appears 4 cycles after the rising RX edge.
  task automatic measure(input int n, input logic is_err, input logic [1:0] rate);
    exp_t e;
    pulse(n);
    e.is_err = is_err;
    e.rate   = rate;
    e.meas   = 16'(n);
    e.at     = cyc + 4;
    sb.push_back(e);
    repeat (10) @(negedge clk);
  endtask

  task automatic relock(input logic [1:0] rate);
    iRelock = 1'b1;
    @(negedge clk);
    iRelock = 1'b0;
    check("relock_drop_locked", {31'd0, oLocked}, 32'd0);
    check("relock_drop_rxen", {31'd0, oRxEn}, 32'd0);
    check("relock_rate_hold", {30'd0, oRate}, {30'd0, rate});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rate"}, {30'd0, oRate}, 32'd0);
    check({tag, "_locked"}, {31'd0, oLocked}, 32'd0);
    check({tag, "_rxen"}, {31'd0, oRxEn}, 32'd0);
    check({tag, "_err"}, {31'd0, oErr}, 32'd0);
    check({tag, "_measure"}, {16'd0, oMeasure}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    RX      = 1'b1;
    iRelock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(300);
    check_reset_outputs("after_idle");

    // 9600-equivalent lock, then 0x55 data bits that must be ignored while locked.
    measure(TB_BIT0, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      RX = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (TB_BIT0) @(negedge clk);
    end
    idle(TB_BIT0);
    check("locked_stable", {31'd0, oLocked}, 32'd1);
    check("locked_measure_hold", {16'd0, oMeasure}, 32'd800);
    check("locked_rate_hold", {30'd0, oRate}, 32'd0);

    // Code 3 and its window edges.
    relock(2'd0);
    idle(260);
    measure(80, 1'b0, 2'd3);
    relock(2'd3);
    idle(260);
    measure(90, 1'b0, 2'd3);
    relock(2'd3);
    idle(260);
    measure(91, 1'b1, 2'd3);
    idle(260);
    measure(69, 1'b1, 2'd3);
    idle(260);
    measure(70, 1'b0, 2'd3);

    // Reject then retry.
    relock(2'd3);
    idle(260);
    measure(600, 1'b1, 2'd3);
    idle(260);
    measure(TB_BIT1, 1'b0, 2'd1);

    // Glitch at idle count 150 restarts arming; an early pulse is not measured.
    relock(2'd1);
    idle(150);
    pulse(5);
    idle(150);
    pulse(160);
    idle(10);
    check("glitch_no_lock", {31'd0, oLocked}, 32'd0);
    idle(260);
    measure(TB_BIT2, 1'b0, 2'd2);

    // Reset mid-measurement.
    relock(2'd2);
    idle(260);
    RX = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    RX = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(260);
    measure(TB_BIT3, 1'b0, 2'd3);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_locked", {31'd0, oLocked}, 32'd1);
    check("final_rate", {30'd0, oRate}, 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
